// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end: deserialises one command word per ss_n frame toward the RAM
// and, for read-data commands, serialises the RAM's response back out on miso.
module spi_slave_ctrl #(
  parameter int MEM_DEPTH = 256,
  localparam int ADDR_SIZE = $clog2(MEM_DEPTH),
  localparam int W = ADDR_SIZE + 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ss_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic [W-1:0]         rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);

  localparam int CW = $clog2(W + 1);
  localparam int TW = $clog2(ADDR_SIZE + 1);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          bit_cnt;
  logic [W-2:0]           rx_shift;
  logic                   rd_addr_received;
  logic [ADDR_SIZE-1:0]   tx_shift;
  logic [TW-1:0]          tx_left;
  logic                   tx_used;
  logic [W-1:0]           word;
  logic                   shift_en, word_done, tx_load, tx_shift_en;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state != IDLE && ss_n) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (!ss_n) state_nxt = CHK_CMD;
        CHK_CMD: state_nxt = mosi ? (rd_addr_received ? READ_DATA : READ_ADD) : WRITE;
        default: state_nxt = state;
      endcase
    end
  end

  // bit_cnt == W marks a completed word; later mosi bits in the frame are dropped.
  always_comb begin
    word        = {rx_shift, mosi};
    shift_en    = !ss_n && (state != IDLE) && (bit_cnt != CW'(W));
    word_done   = shift_en && (bit_cnt == CW'(W - 1));
    tx_load     = !ss_n && (state == READ_DATA) && (bit_cnt == CW'(W)) && !tx_used && tx_valid;
    tx_shift_en = !ss_n && (tx_left != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt          <= '0;
      rx_shift         <= '0;
      rx_data          <= '0;
      rx_valid         <= 1'b0;
      rd_addr_received <= 1'b0;
      tx_shift         <= '0;
      tx_left          <= '0;
      tx_used          <= 1'b0;
      miso             <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (ss_n) begin
        bit_cnt <= '0;
        tx_left <= '0;
        tx_used <= 1'b0;
        miso    <= 1'b0;
      end else begin
        if (shift_en) begin
          rx_shift <= word[W-2:0];
          bit_cnt  <= bit_cnt + 1'b1;
        end
        if (word_done) begin
          rx_data  <= word;
          rx_valid <= 1'b1;
          if (word[W-1]) rd_addr_received <= ~word[W-2];
        end
        // First response bit goes out straight from tx_data; the rest from tx_shift.
        if (tx_load) begin
          miso     <= tx_data[ADDR_SIZE-1];
          tx_shift <= {tx_data[ADDR_SIZE-2:0], 1'b0};
          tx_left  <= TW'(ADDR_SIZE - 1);
          tx_used  <= 1'b1;
        end else if (tx_shift_en) begin
          miso     <= tx_shift[ADDR_SIZE-1];
          tx_shift <= tx_shift << 1;
          tx_left  <= tx_left - 1'b1;
        end else begin
          miso <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Randomised frame-level bench for spi_slave_ctrl with a frame-granular reference model.
module tb_spi_slave_ctrl;

  localparam int MEM_DEPTH = 256;
  localparam int A = 8;
  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst_n, ss_n, mosi, miso, rx_valid, tx_valid;
  logic [W-1:0] rx_data;
  logic [A-1:0] tx_data;

  always #5 clk = ~clk;

  spi_slave_ctrl #(.MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ss_n(ss_n), .mosi(mosi), .miso(miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
  );

  int checks = 0;
  int errors = 0;

  // Model state: read-address flag and last forwarded word.
  bit           m_flag;
  logic [W-1:0] m_rx;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One frame: ss_n low for posedges 0..len-1, high (or reset) at posedge len.
  task automatic run_frame(input logic [W-1:0] word, input int len, input bit give_tx,
                           input logic [A-1:0] txd, input int d, input bit do_rst);
    logic [63:0]  obs_v, obs_m, exp_v, exp_m;
    logic [W-1:0] rx_first, prev;
    bit           full, rd;
    int           t0;
    full  = (len - 1 >= W);
    rd    = full && word[W-1] && m_flag;
    t0    = W + d;
    exp_v = '0;
    exp_m = '0;
    if (full) exp_v[W] = 1'b1;
    if (rd && give_tx)
      for (int i = 0; i < A; i++)
        if (t0 + i <= len - 1) exp_m[t0+i] = txd[A-1-i];
    obs_v    = '0;
    obs_m    = '0;
    rx_first = '0;
    for (int p = 0; p <= len; p++) begin
      @(negedge clk);
      if (p > 0) begin
        obs_v[p-1] = rx_valid;
        obs_m[p-1] = miso;
        if (p == 1) rx_first = rx_data;
      end
      ss_n = (p < len) ? 1'b0 : 1'b1;
      if (do_rst && p == len) rst_n = 1'b0;
      mosi    = (p >= 1 && p <= W) ? word[W-p] : 1'($urandom);
      tx_data = A'($urandom);
      if (rd && give_tx && p == t0) begin
        tx_valid = 1'b1;
        tx_data  = txd;
      end else if (rd && p > W && (!give_tx || p < t0)) begin
        tx_valid = 1'b0;
      end else begin
        tx_valid = ($urandom_range(0, 3) == 0);
      end
    end
    @(negedge clk);
    obs_v[len] = rx_valid;
    obs_m[len] = miso;
    prev = m_rx;
    if (full) begin
      m_rx = word;
      if (word[W-1]) m_flag = ~word[W-2];
    end
    if (do_rst) begin
      m_rx   = '0;
      m_flag = 1'b0;
    end
    check("rx_hold", 64'(rx_first), 64'(prev));
    check("rx_valid", obs_v, exp_v);
    check("miso", obs_m, exp_m);
    check("rx_data", 64'(rx_data), 64'(m_rx));
    rst_n    = 1'b1;
    ss_n     = 1'b1;
    tx_valid = 1'b0;
    @(negedge clk);
    check("idle", 64'({miso, rx_valid}), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
    m_flag = 1'b0; m_rx = '0;
    repeat (3) @(negedge clk);
    check("reset", 64'({miso, rx_valid, rx_data}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_frame(10'h03A, W + 3, 1'b0, 8'h00, 1, 1'b0);          // write address
    run_frame(10'h1A5, W + 3, 1'b1, 8'h3C, 1, 1'b0);          // write data
    run_frame(10'h23A, W + 2, 1'b0, 8'h00, 1, 1'b0);          // read address
    run_frame(10'h300, W + A + 5, 1'b1, 8'hA5, 2, 1'b0);      // read data, 0xA5 out
    run_frame(10'h300, W + A + 6, 1'b1, 8'h5A, 2, 1'b0);      // no prior address: READ_ADD
    run_frame(10'h300, W + A + 6, 1'b1, 8'hC3, 1, 1'b0);
    run_frame(10'h155, 6, 1'b0, 8'h00, 1, 1'b0);              // abort after 5 bits
    run_frame(10'h0FF, W + 1, 1'b0, 8'h00, 1, 1'b0);
    run_frame(10'h23A, W + 2, 1'b0, 8'h00, 1, 1'b0);
    run_frame(10'h300, W + 2 + 3, 1'b1, 8'hA5, 2, 1'b1);      // reset after 3 miso bits
    run_frame(10'h300, W + A + 6, 1'b1, 8'hA5, 2, 1'b0);
    run_frame(10'h2F0, W + 1, 1'b0, 8'h00, 1, 1'b0);
    run_frame(10'h3FF, W + 5, 1'b1, 8'hFF, 1, 1'b0);          // ss_n rises mid shift-out

    for (int n = 0; n < 80; n++) begin
      logic [W-1:0] w;
      int           len;
      w = W'($urandom);
      if ($urandom_range(0, 2) == 0) w[W-1] = 1'b1;
      if ($urandom_range(0, 4) == 0) len = $urandom_range(1, W);
      else                           len = W + 1 + $urandom_range(0, A + 5);
      run_frame(w, len, ($urandom_range(0, 3) != 0), A'($urandom), $urandom_range(1, 3),
                ($urandom_range(0, 14) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
